// File: rtl/gpio_debounce_if.sv
// Signal bundle for one gpio_debounce channel group.
// master drives the pads and threshold; slave is the conditioner side.
interface gpio_debounce_if #(
    parameter int unsigned Width    = 13,
    parameter int unsigned CntWidth = 8
);
    logic [Width-1:0]    raw;
    logic [CntWidth-1:0] threshold;
    logic [Width-1:0]    level;
    logic [Width-1:0]    rise;
    logic [Width-1:0]    fall;
    logic                any_event;
    logic                tick;

    modport master (
        output raw,
        output threshold,
        input  level,
        input  rise,
        input  fall,
        input  any_event,
        input  tick
    );

    modport slave (
        input  raw,
        input  threshold,
        output level,
        output rise,
        output fall,
        output any_event,
        output tick
    );
endinterface

// File: rtl/gpio_debounce.sv
// Pad input conditioner: synchroniser, polarity fix, tick-based
// debounce filter and registered rise/fall event pulses per channel.
module gpio_debounce #(
    parameter int unsigned     Width       = 13,
    parameter int unsigned     SyncStages  = 2,
    parameter int unsigned     CntWidth    = 8,
    parameter int unsigned     PrescaleDiv = 30000,
    parameter logic [Width-1:0] InvertMask = '1,
    parameter logic [Width-1:0] ResetRaw   = '1
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_ni,
    input  logic [Width-1:0]    raw_i,
    input  logic [CntWidth-1:0] threshold_i,
    output logic [Width-1:0]    level_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o,
    output logic                any_event_o,
    output logic                tick_o
);

    localparam int unsigned PreW =
        (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PrescaleDiv - 1);
    localparam logic [Width-1:0] ResetLevel = ResetRaw ^ InvertMask;

    logic [Width-1:0]    sync_q [SyncStages];
    logic [Width-1:0]    pol_q;
    logic [Width-1:0]    pol_d;
    logic [Width-1:0]    stable_q;
    logic [Width-1:0]    stable_d;
    logic [Width-1:0]    rise_q;
    logic [Width-1:0]    rise_d;
    logic [Width-1:0]    fall_q;
    logic [Width-1:0]    fall_d;
    logic                any_q;
    logic                any_d;
    logic [PreW-1:0]     pre_q;
    logic [PreW-1:0]     pre_d;
    logic [CntWidth-1:0] cnt_q [Width];
    logic [CntWidth-1:0] cnt_d [Width];
    logic [CntWidth-1:0] thr_m1;
    logic                bypass;
    logic                tick;

    // Held low during reset so observers never see a stray tick.
    assign tick  = rst_sys_ni & (pre_q == PreMax);
    assign pre_d = tick ? '0 : pre_q + PreW'(1);

    // Polarity is applied in a register after the synchroniser.
    assign pol_d = sync_q[SyncStages-1] ^ InvertMask;

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                sync_q[s] <= ResetRaw;
            end
            pol_q <= ResetLevel;
        end else begin
            sync_q[0] <= raw_i;
            for (int s = 1; s < SyncStages; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            pol_q <= pol_d;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    always_comb begin
        thr_m1   = threshold_i - CntWidth'(1);
        bypass   = (threshold_i == '0);
        stable_d = stable_q;
        for (int i = 0; i < Width; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pol_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (bypass || (tick && cnt_q[i] >= thr_m1)) begin
                stable_d[i] = pol_q[i];
                cnt_d[i]    = '0;
            end else if (tick && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
        end
        rise_d = stable_d & ~stable_q;
        fall_d = stable_q & ~stable_d;
        any_d  = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            for (int i = 0; i < Width; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= ResetLevel;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
        end else begin
            for (int i = 0; i < Width; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= any_d;
        end
    end

    assign level_o     = stable_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign any_event_o = any_q;
    assign tick_o      = tick;

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: one instance ticking every cycle,
// one with a divide-by-4 prescaler, both 4 channels wide.
module tb_gpio_debounce;

    typedef struct {
        int         c;
        logic [3:0] lv;
        logic [3:0] r;
        logic [3:0] f;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_debounce_if #(.Width(4), .CntWidth(8)) b1 ();
    gpio_debounce_if #(.Width(4), .CntWidth(8)) b4 ();

    gpio_debounce #(
        .Width(4), .SyncStages(2), .CntWidth(8), .PrescaleDiv(1),
        .InvertMask(4'hF), .ResetRaw(4'hF)
    ) dut1 (
        .clk_sys_i(clk), .rst_sys_ni(rst_n),
        .raw_i(b1.raw), .threshold_i(b1.threshold),
        .level_o(b1.level), .rise_o(b1.rise), .fall_o(b1.fall),
        .any_event_o(b1.any_event), .tick_o(b1.tick)
    );

    gpio_debounce #(
        .Width(4), .SyncStages(2), .CntWidth(8), .PrescaleDiv(4),
        .InvertMask(4'hF), .ResetRaw(4'hF)
    ) dut4 (
        .clk_sys_i(clk), .rst_sys_ni(rst_n),
        .raw_i(b4.raw), .threshold_i(b4.threshold),
        .level_o(b4.level), .rise_o(b4.rise), .fall_o(b4.fall),
        .any_event_o(b4.any_event), .tick_o(b4.tick)
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
        end
    endtask

    task automatic push1(input int c, input logic [3:0] lv,
                         input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.c = c; e.lv = lv; e.r = r; e.f = f;
        q1.push_back(e);
    endtask

    task automatic push4(input int c, input logic [3:0] lv,
                         input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.c = c; e.lv = lv; e.r = r; e.f = f;
        q4.push_back(e);
    endtask

    task automatic next_tick(output int t);
        t = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (b4.tick) begin
                t = cyc;
                break;
            end
        end
    endtask

    // Commit edge for dut4, threshold 2: first tick-qualified edge at or
    // after first-sample edge k plus 3, then one further tick.
    function automatic int commit4(input int k, input int t0);
        int e;
        e = t0 + 1;
        while (e < k + 3) e += 4;
        return e + 4;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (b1.any_event || |b1.rise || |b1.fall)) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_event cyc=%0d lv=%h r=%h f=%h",
                         cyc, b1.level, b1.rise, b1.fall);
            end else begin
                e = q1.pop_front();
                if (cyc != e.c || b1.level != e.lv || b1.rise != e.r ||
                    b1.fall != e.f || b1.any_event !== 1'b1) begin
                    errors++;
                    $display("FAIL dut1_event got cyc=%0d lv=%h r=%h f=%h any=%b want cyc=%0d lv=%h r=%h f=%h any=1",
                             cyc, b1.level, b1.rise, b1.fall, b1.any_event,
                             e.c, e.lv, e.r, e.f);
                end
            end
        end
        if (mon_en && (b4.any_event || |b4.rise || |b4.fall)) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL dut4_unexpected_event cyc=%0d lv=%h r=%h f=%h",
                         cyc, b4.level, b4.rise, b4.fall);
            end else begin
                e = q4.pop_front();
                if (cyc != e.c || b4.level != e.lv || b4.rise != e.r ||
                    b4.fall != e.f || b4.any_event !== 1'b1) begin
                    errors++;
                    $display("FAIL dut4_event got cyc=%0d lv=%h r=%h f=%h any=%b want cyc=%0d lv=%h r=%h f=%h any=1",
                             cyc, b4.level, b4.rise, b4.fall, b4.any_event,
                             e.c, e.lv, e.r, e.f);
                end
            end
        end
    end

    initial begin
        int k;
        int k2;
        int t0;
        int t1;
        int t2;

        rst_n        = 1'b0;
        b1.raw       = 4'hF;
        b4.raw       = 4'hF;
        b1.threshold = 8'd3;
        b4.threshold = 8'd2;

        repeat (3) @(negedge clk);
        chk("rst_level1", b1.level, 0);
        chk("rst_rise1", b1.rise, 0);
        chk("rst_fall1", b1.fall, 0);
        chk("rst_any1", b1.any_event, 0);
        chk("rst_tick1", b1.tick, 0);
        chk("rst_level4", b4.level, 0);
        chk("rst_any4", b4.any_event, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("tick1_const", b1.tick, 1);

        // Clean press on ch0, latency 5 edges, then release
        b1.raw[0] = 1'b0;
        push1(cyc + 1 + 5, 4'b0001, 4'b0001, 4'b0000);
        repeat (10) @(negedge clk);
        chk("press_level", b1.level, 1);
        b1.raw[0] = 1'b1;
        push1(cyc + 1 + 5, 4'b0000, 4'b0000, 4'b0001);
        repeat (10) @(negedge clk);

        // Two-cycle glitch on ch1 must be rejected
        b1.raw[1] = 1'b0;
        repeat (2) @(negedge clk);
        b1.raw[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_level", b1.level, 0);
        chk("glitch_cnt", dut1.cnt_q[1], 0);

        // Prescaler period
        next_tick(t0);
        next_tick(t1);
        next_tick(t2);
        chk("tick_seen", (t0 >= 0) ? 1 : 0, 1);
        chk("tick_period_a", t1 - t0, 4);
        chk("tick_period_b", t2 - t1, 4);

        // Bounce on dut4 ch3, then settle pressed
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b4.raw[3] = (i % 2 == 1);
        end
        @(negedge clk);
        b4.raw[3] = 1'b0;
        k = cyc + 1;
        push4(commit4(k, t0), 4'b1000, 4'b1000, 4'b0000);
        repeat (16) @(negedge clk);
        chk("bounce_level", b4.level, 8);
        b4.raw[3] = 1'b1;
        k = cyc + 1;
        push4(commit4(k, t0), 4'b0000, 4'b0000, 4'b1000);
        repeat (16) @(negedge clk);

        // Bypass: all channels at once
        b1.threshold = 8'd0;
        b1.raw       = 4'h0;
        push1(cyc + 1 + 3, 4'hF, 4'hF, 4'h0);
        repeat (6) @(negedge clk);
        b1.raw = 4'hF;
        push1(cyc + 1 + 3, 4'h0, 4'h0, 4'hF);
        repeat (6) @(negedge clk);

        // Reset mid-count, then lower threshold mid-count
        b1.threshold = 8'd10;
        b1.raw[2]    = 1'b0;
        repeat (8) @(negedge clk);
        chk("midcnt_5", dut1.cnt_q[2], 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_level", b1.level, 0);
        chk("midrst_cnt", dut1.cnt_q[2], 0);
        rst_n = 1'b1;
        k2 = cyc + 1;
        push1(k2 + 6, 4'b0100, 4'b0100, 4'b0000);
        repeat (6) @(negedge clk);
        chk("relcnt_3", dut1.cnt_q[2], 3);
        b1.threshold = 8'd2;
        repeat (6) @(negedge clk);
        chk("lowthr_level", b1.level, 4);
        b1.threshold = 8'd0;
        b1.raw[2]    = 1'b1;
        push1(cyc + 1 + 3, 4'b0000, 4'b0000, 4'b0100);
        repeat (8) @(negedge clk);

        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
